mdio_ctrl: RTL and testbench
============================

# mdio_ctrl

PHY management controller for the MAC. It sequences the shared PHY hardware reset (`phy_rst_b`) after system reset and generates MDC. It then serves a single requester with IEEE 802.3 Clause 22 MDIO read/write frames. The `mdio` inout tristate buffer sits in `mac`; this block only drives `mdio_o`/`mdio_oe` and samples `mdio_i`.

## Interface
- `MDC_DIV`, 10: clk cycles per MDC half-period. MDC = 25 MHz / (2·MDC_DIV) = 1.25 MHz.
- `RST_CYCLES`, 250000: cycles `phy_rst_b` is held low (10 ms).
- `RST_WAIT`, 125000: cycles after `phy_rst_b` rises before the first frame (5 ms).
- `PHY_ADDR`, 5'd0: PHYAD field of every frame.
- `INIT_BMCR`, 16'h2100: BMCR auto-init value. Used only with `MDIO_AUTOINIT_EN`.
- `clk_25mhz`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_reg`  in  5  REGAD.
- `req_wdata`  in  16  write data.
- `rsp_valid`  out  1  one-cycle pulse when a requested frame completes.
- `rsp_rdata`  out  16  read data. Holds its value until the next read completes.
- `rsp_err`  out  1  read turnaround error. Valid with `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `phy_rst_b`  out  1  PHY reset, active-low.
- `mdc`  out  1  management clock.
- `mdio_o`  out  1  MDIO output data.
- `mdio_oe`  out  1  MDIO output enable.
- `mdio_i`  in  1  MDIO input.

## Operation
- **Reset values:**
  - `phy_rst_b`=0, `mdc`=0, `mdio_o`=1, `mdio_oe`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=1.
- **States:** RST_HOLD → RST_WAIT → [INIT] → IDLE ↔ SHIFT → DONE → IDLE.
- **RST_HOLD:** `phy_rst_b`=0 for RST_CYCLES cycles, then `phy_rst_b`=1.
- **RST_WAIT:** count RST_WAIT cycles.
- **IDLE:**
  - `req_ready`=1, `mdc`=0, `mdio_oe`=0.
  - On `req_valid && req_ready`, capture `req_write`, `req_reg` and `req_wdata`, then go to SHIFT.
- **SHIFT:** 64 bits, index 0–63, MSB first per field.
  - Bits 0–31: preamble, all 1.
  - Bits 32–33: ST = 01.
  - Bits 34–35: OP = 01 for write, 10 for read.
  - Bits 36–40: PHYAD.
  - Bits 41–45: REGAD.
  - Bits 46–47: TA. Write drives 10. Read releases the line (`mdio_oe`=0 from bit 46 through 63).
  - Bits 48–63: data. Write drives `req_wdata`. Read samples into a shift register.
- **Read error check:** `rsp_err` = 1 when the sample taken in bit 47 is not 0. Data is captured regardless; an absent PHY with pull-up gives 0xFFFF.
- **DONE:**
  - `mdc`=0, `mdio_oe`=0.
  - Requested frame: `rsp_valid`=1 for one cycle, and `rsp_rdata` is updated on reads.
  - Next state is IDLE.
- **Request during SHIFT:** not accepted (`req_ready`=0). The requester holds `req_valid`.
- **`rst` low in any state, including mid-frame:** all outputs return to reset values on the next edge, the frame is abandoned without `rsp_valid`, and the sequence restarts at RST_HOLD.

## Timing
- Each bit lasts 2·MDC_DIV cycles:
  - `mdc`=0 for the first MDC_DIV cycles, then 1 for MDC_DIV cycles.
  - `mdio_o`/`mdio_oe` change only on the first cycle of the low phase.
  - `mdio_i` is sampled on the last cycle of the low phase.
- Handshake at cycle T: the first low phase starts at T+1. The frame occupies 128·MDC_DIV cycles. DONE follows, so `rsp_valid` asserts at T+1+128·MDC_DIV.
- `req_ready` returns to 1 the cycle after `rsp_valid`.
- Reset release: `phy_rst_b` rises RST_CYCLES cycles after `rst` goes high. `req_ready` rises RST_WAIT cycles later (without auto-init).
- Counters are sized by `$clog2` of the parameter. Zero-value parameters are illegal.

## Configuration
- **`MDIO_AUTOINIT_EN` defined:**
  - After RST_WAIT, state INIT issues an internal write of INIT_BMCR to register 0 using standard SHIFT timing.
  - No `rsp_valid` is produced, and `req_ready` stays 0 until the internal write completes, then the block enters IDLE.
- **Not defined:** RST_WAIT goes straight to IDLE, and INIT_BMCR is unused.

## Structure
- **Package `mdio_pkg`:**
  - State enum.
  - Constants: ST_CODE=2'b01, OP_WR=2'b01, OP_RD=2'b10, FRAME_BITS=64, TA_BIT=46, DATA_BIT=48.
  - Register addresses: BMCR_ADDR=5'd0, BMSR_ADDR=5'd1.
- **Sub-module `mdc_gen`:** MDC_DIV half-period counter. Outputs `mdc`, a `bit_start` strobe (first low cycle) and a `sample` strobe (last low cycle), and is held in reset while idle.

## Test plan
All scenarios use MDC_DIV=2, RST_CYCLES=8, RST_WAIT=4 and PHY_ADDR=1, with a bench MDIO PHY model.
- **Reset sequencing:** release `rst` → `phy_rst_b` low for 8 cycles, then high; `req_ready` rises 4 cycles later; `mdc` stays 0 throughout.
- **Write:** write reg 0x04 with data 0x01E1 → model decodes 32×1, 01 01 00001 00100 10 0000000111100001; `rsp_valid` 257 cycles after the handshake.
- **Read:** read reg 0x01 while the model drives TA=0 and data 0x786D → `rsp_rdata`=0x786D, `rsp_err`=0; `mdio_oe`=0 from bit 46 on.
- **Absent PHY:** read with `mdio_i` tied 1 → `rsp_rdata`=0xFFFF, `rsp_err`=1.
- **Mid-frame reset:** assert `rst` low during bit 20 of a write → all outputs at reset values next cycle, no `rsp_valid`, full reset sequence replays.
- **Auto-init (`MDIO_AUTOINIT_EN`):** after reset → first frame is a write of reg 0 with 0x2100; `req_ready` stays 0 until it finishes; no `rsp_valid`.

Source files
------------

// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdio_pkg
// Description : Shared types, Clause 22 frame constants and frame builder for
//               the MDIO management controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mdio_pkg;

  typedef enum logic [2:0] {
    S_RST_HOLD = 3'd0,
    S_RST_WAIT = 3'd1,
    S_INIT     = 3'd2,
    S_IDLE     = 3'd3,
    S_SHIFT    = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam logic [1:0] ST_CODE    = 2'b01;
  localparam logic [1:0] OP_WR      = 2'b01;
  localparam logic [1:0] OP_RD      = 2'b10;
  localparam int         FRAME_BITS = 64;
  localparam int         TA_BIT     = 46;
  localparam int         DATA_BIT   = 48;

  localparam logic [4:0] BMCR_ADDR  = 5'd0;
  localparam logic [4:0] BMSR_ADDR  = 5'd1;

  // Whole frame, bit index 0 of the wire in [63]. Read frames carry ones in
  // the released TA/data positions; those bits are never driven.
  function automatic logic [63:0] build_frame(input logic        wr,
                                              input logic [4:0]  phyad,
                                              input logic [4:0]  regad,
                                              input logic [15:0] wdata);
    return {32'hFFFF_FFFF, ST_CODE, (wr ? OP_WR : OP_RD), phyad, regad,
            (wr ? 2'b10 : 2'b11), (wr ? wdata : 16'hFFFF)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_ctrl_mdc_gen.sv
`default_nettype none
// ============================================================================
// Module      : mdc_gen
// Description : MDC generator. One bit period is 2*MDC_DIV clocks, low half
//               first. Held at count 0 / MDC low while run_i is low.
// Revision    : 1.0 - initial release
// ============================================================================
module mdc_gen #(
  parameter int unsigned MDC_DIV = 10
) (
  input  logic clk,
  input  logic rst,          // synchronous, active-low
  input  logic run_i,
  output logic mdc_o,
  output logic bit_start_o,  // edge ending this cycle opens the next bit's low phase
  output logic sample_o      // this is the last low cycle of the bit
);

  localparam int unsigned    CW        = $clog2(2 * MDC_DIV);
  localparam logic [CW-1:0]  HALF_LAST = CW'(MDC_DIV - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(2 * MDC_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          mdc_q;

  // Bit-period counter with MDC registered from it so MDC is glitch-free.
  always_ff @(posedge clk) begin
    if (!rst || !run_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (cnt_q == BIT_LAST) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == HALF_LAST) begin
        mdc_q <= 1'b1;
      end
    end
  end

  assign mdc_o       = mdc_q;
  assign bit_start_o = run_i && (cnt_q == BIT_LAST);
  assign sample_o    = run_i && (cnt_q == HALF_LAST);

endmodule
`default_nettype wire

// File: rtl/mdio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdio_ctrl
// Description : PHY reset sequencer plus Clause 22 MDIO read/write master for
//               a single requester. Optional build macro MDIO_AUTOINIT_EN
//               writes INIT_BMCR to BMCR once after the PHY reset wait.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_ctrl
  import mdio_pkg::*;
#(
  parameter int unsigned MDC_DIV    = 10,
  parameter int unsigned RST_CYCLES = 250000,
  parameter int unsigned RST_WAIT   = 125000,
  parameter logic [4:0]  PHY_ADDR   = 5'd0,
  parameter logic [15:0] INIT_BMCR  = 16'h2100
) (
  input  logic        clk_25mhz,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        phy_rst_b,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int unsigned   CNT_MAX   = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
  localparam int unsigned   CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(RST_WAIT - 1);
  localparam logic [5:0]    LAST_BIT  = 6'(FRAME_BITS - 1);
  localparam logic [5:0]    TA_IDX    = 6'(TA_BIT);
  localparam logic [5:0]    TA_SAMPLE = 6'(TA_BIT + 1);
  localparam logic [5:0]    DATA_IDX  = 6'(DATA_BIT);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    bit_idx_q;
  logic [62:0]   frame_q;      // bits still to be sent after the current one
  logic          wr_q;
  logic          int_q;        // internal (auto-init) frame: no response
  logic [15:0]   rx_q;
  logic          ta_err_q;
  logic          req_ready_q, rsp_valid_q, rsp_err_q, busy_q;
  logic          phy_rst_b_q, mdio_o_q, mdio_oe_q;
  logic [15:0]   rsp_rdata_q;

  logic          start_d, start_wr_d, start_int_d;
  logic [4:0]    start_reg_d;
  logic [15:0]   start_data_d;
  logic [63:0]   frame_d;
  logic          w_bit_start, w_sample;

  mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc_gen (
    .clk         (clk_25mhz),
    .rst         (rst),
    .run_i       (state_q == S_SHIFT),
    .mdc_o       (mdc),
    .bit_start_o (w_bit_start),
    .sample_o    (w_sample)
  );

  // Select the frame source: an accepted request or the internal BMCR write.
  always_comb begin
    start_d      = 1'b0;
    start_wr_d   = req_write;
    start_int_d  = 1'b0;
    start_reg_d  = req_reg;
    start_data_d = req_wdata;
    if (state_q == S_IDLE && req_valid && req_ready_q) begin
      start_d = 1'b1;
    end else if (state_q == S_INIT) begin
      start_d      = 1'b1;
      start_wr_d   = 1'b1;
      start_int_d  = 1'b1;
      start_reg_d  = BMCR_ADDR;
      start_data_d = INIT_BMCR;
    end
  end

  assign frame_d = build_frame(start_wr_d, PHY_ADDR, start_reg_d, start_data_d);

  // Controller FSM with registered outputs.
  always_ff @(posedge clk_25mhz) begin
    if (!rst) begin
      state_q     <= S_RST_HOLD;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      frame_q     <= '1;
      wr_q        <= 1'b0;
      int_q       <= 1'b0;
      rx_q        <= '0;
      ta_err_q    <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b1;
      phy_rst_b_q <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (start_d) begin
        // Bit 0 goes on the wire with the first low cycle.
        state_q     <= S_SHIFT;
        wr_q        <= start_wr_d;
        int_q       <= start_int_d;
        frame_q     <= frame_d[62:0];
        bit_idx_q   <= '0;
        mdio_o_q    <= frame_d[63];
        mdio_oe_q   <= 1'b1;
        req_ready_q <= 1'b0;
        busy_q      <= 1'b1;
      end else begin
        case (state_q)
          S_RST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              cnt_q       <= '0;
              phy_rst_b_q <= 1'b1;
              state_q     <= S_RST_WAIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_RST_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
              cnt_q <= '0;
`ifdef MDIO_AUTOINIT_EN
              state_q <= S_INIT;
`else
              state_q     <= S_IDLE;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_SHIFT: begin
            if (w_sample) begin
              if (bit_idx_q == TA_SAMPLE) begin
                ta_err_q <= mdio_i;
              end
              if (bit_idx_q >= DATA_IDX) begin
                rx_q <= {rx_q[14:0], mdio_i};
              end
            end
            if (w_bit_start) begin
              if (bit_idx_q == LAST_BIT) begin
                state_q   <= S_DONE;
                mdio_o_q  <= 1'b1;
                mdio_oe_q <= 1'b0;
                if (!int_q) begin
                  rsp_valid_q <= 1'b1;
                  if (wr_q) begin
                    rsp_err_q <= 1'b0;
                  end else begin
                    rsp_rdata_q <= rx_q;
                    rsp_err_q   <= ta_err_q;
                  end
                end
              end else begin
                // Reads release the line from TA onward.
                bit_idx_q <= bit_idx_q + 1'b1;
                frame_q   <= {frame_q[61:0], 1'b1};
                mdio_o_q  <= frame_q[62];
                mdio_oe_q <= wr_q || ((bit_idx_q + 6'd1) < TA_IDX);
              end
            end
          end
          S_DONE: begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign phy_rst_b = phy_rst_b_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mdio_ctrl
// Description : Self-checking bench for mdio_ctrl with a behavioural MDIO PHY
//               that decodes frames on MDC rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_ctrl;

  localparam int unsigned MDC_DIV_TB    = 2;
  localparam int unsigned RST_CYCLES_TB = 8;
  localparam int unsigned RST_WAIT_TB   = 4;
  localparam logic [4:0]  PHY_ADDR_TB   = 5'd1;
  localparam int          FRAME_LAT     = 1 + 128 * MDC_DIV_TB;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_write;
  logic [4:0]  req_reg;
  logic [15:0] req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_err, busy, phy_rst_b, mdc, mdio_o, mdio_oe, mdio_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_rdata;

  // PHY model state
  bit          q_o[$];
  bit          q_oe[$];
  bit          phy_absent;
  logic [15:0] phy_data;

  mdio_ctrl #(
    .MDC_DIV    (MDC_DIV_TB),
    .RST_CYCLES (RST_CYCLES_TB),
    .RST_WAIT   (RST_WAIT_TB),
    .PHY_ADDR   (PHY_ADDR_TB),
    .INIT_BMCR  (16'h2100)
  ) dut (
    .clk_25mhz (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .phy_rst_b (phy_rst_b),
    .mdc       (mdc),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .mdio_i    (mdio_i)
  );

  always #20 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // PHY: records each bit at MDC rise; for a read addressed to it, drives TA=0
  // then data MSB first, changing after the rising edge of the previous bit.
  initial begin : phy_model
    bit respond;
    respond = 1'b0;
    mdio_i  = 1'b1;
    forever begin
      @(posedge mdc);
      q_o.push_back(mdio_o);
      q_oe.push_back(mdio_oe);
      if (q_o.size() == 47) begin
        respond = !phy_absent && ({q_o[32], q_o[33]} == 2'b01) &&
                  ({q_o[34], q_o[35]} == 2'b10) &&
                  ({q_o[36], q_o[37], q_o[38], q_o[39], q_o[40]} == PHY_ADDR_TB);
        mdio_i = respond ? 1'b0 : 1'b1;
      end else if (respond && q_o.size() >= 48 && q_o.size() <= 63) begin
        mdio_i = phy_data[63 - q_o.size()];
      end else begin
        mdio_i = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] out_vec();
    return {phy_rst_b, mdc, mdio_o, mdio_oe, req_ready, rsp_valid, rsp_err, busy, rsp_rdata, 1'b0};
  endfunction

  localparam logic [24:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0};

  task automatic decode(output logic [63:0] f, output logic [63:0] oe);
    f  = '0;
    oe = '0;
    foreach (q_o[i]) begin
      if (i < 64) begin
        f[63 - i]  = q_o[i];
        oe[63 - i] = q_oe[i];
      end
    end
  endtask

  task automatic reset_seq();
    int          cnt, w;
    bit          mdc_seen, rsp_seen;
    logic [63:0] f, oe;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(out_vec()), 64'(RESET_VEC));
    last_rdata = 16'h0;
    rst = 1'b1;
    q_o.delete();
    q_oe.delete();
    cnt = 1;
    mdc_seen = 1'b0;
    rsp_seen = 1'b0;
    while (!phy_rst_b && cnt < 100) begin
      @(negedge clk);
      if (!phy_rst_b) cnt++;
      if (mdc) mdc_seen = 1'b1;
    end
    chk("phy_rst_low_cycles", 64'(cnt), 64'(RST_CYCLES_TB));
    w = 0;
    while (!req_ready && w < 1000) begin
      @(negedge clk);
      w++;
      if (mdc) mdc_seen = 1'b1;
      if (rsp_valid) rsp_seen = 1'b1;
    end
`ifdef MDIO_AUTOINIT_EN
    chk("ready_after_init", 64'(w), 64'(RST_WAIT_TB + 1 + 128 * MDC_DIV_TB + 1));
    decode(f, oe);
    chk("init_frame_bits", f, {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR_TB, 5'd0, 2'b10, 16'h2100});
    chk("init_frame_oe", oe, {64{1'b1}});
    chk("init_no_rsp", 64'(rsp_seen), 64'd0);
`else
    chk("ready_after_phy_rst", 64'(w), 64'(RST_WAIT_TB));
    chk("mdc_idle_in_reset", 64'(mdc_seen), 64'd0);
    chk("no_rsp_in_reset", 64'(rsp_seen), 64'd0);
    f  = '0;
    oe = '0;
`endif
  endtask

  task automatic issue(input bit wr, input logic [4:0] ra, input logic [15:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", 64'(req_ready), 64'd1);
    q_o.delete();
    q_oe.delete();
    req_valid = 1'b1;
    req_write = wr;
    req_reg   = ra;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_reg   = 5'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic run_txn(input bit wr, input logic [4:0] ra, input logic [15:0] wd,
                         input bit absent, input logic [15:0] pdata);
    int          lat;
    logic [63:0] f, oe, exp_f, exp_oe;
    logic [15:0] exp_rd;
    phy_absent = absent;
    phy_data   = pdata;
    issue(wr, ra, wd);
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", 64'(lat), 64'(FRAME_LAT));
    chk("mdc_edges", 64'(q_o.size()), 64'd64);
    decode(f, oe);
    exp_f  = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), PHY_ADDR_TB, ra, 2'b10, wd};
    exp_oe = wr ? {64{1'b1}} : ({64{1'b1}} << 18);
    chk("frame_oe", oe, exp_oe);
    chk("frame_bits", f & exp_oe, exp_f & exp_oe);
    if (!wr) begin
      exp_rd     = absent ? 16'hFFFF : pdata;
      last_rdata = exp_rd;
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
      chk("rsp_err", 64'(rsp_err), 64'(absent));
    end else begin
      chk("rdata_hold_on_write", 64'(rsp_rdata), 64'(last_rdata));
    end
    @(negedge clk);
    chk("post_rsp_flags", 64'({rsp_valid, req_ready, busy}), 64'(3'b010));
    chk("rdata_stable", 64'(rsp_rdata), 64'(last_rdata));
  endtask

  task automatic midframe_reset();
    int n;
    bit saw;
    phy_absent = 1'b0;
    issue(1'b1, 5'($urandom), 16'($urandom));
    n   = 0;
    saw = 1'b0;
    while (q_o.size() < 21 && n < 2000) begin
      @(negedge clk);
      n++;
      if (rsp_valid) saw = 1'b1;
    end
    chk("midframe_at_bit20", 64'(q_o.size()), 64'd21);
    rst = 1'b0;
    @(negedge clk);
    chk("midframe_reset_state", 64'(out_vec()), 64'(RESET_VEC));
    repeat (300) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    chk("midframe_no_rsp", 64'(saw), 64'd0);
    reset_seq();
  endtask

  initial begin : stim
    bit          wr, ab;
    logic [4:0]  ra;
    logic [15:0] wd, pd;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_reg    = '0;
    req_wdata  = '0;
    phy_absent = 1'b0;
    phy_data   = '0;
    last_rdata = '0;

    reset_seq();
    run_txn(1'b1, 5'h04, 16'h01E1, 1'b0, 16'h0000);
    run_txn(1'b0, mdio_pkg::BMSR_ADDR, 16'h0000, 1'b0, 16'h786D);
    run_txn(1'b0, 5'h02, 16'h0000, 1'b1, 16'h0000);
    run_txn(1'b1, 5'h1F, 16'hFFFF, 1'b0, 16'h0000);
    run_txn(1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
    repeat (8) begin
      wr = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0);
      ra = 5'($urandom);
      wd = 16'($urandom);
      pd = 16'($urandom);
      run_txn(wr, ra, wd, ab, pd);
    end
    midframe_reset();
    run_txn(1'b0, 5'h03, 16'h0000, 1'b0, 16'($urandom));
    run_txn(1'b1, 5'h09, 16'($urandom), 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
